// File: rtl/debug_tx_framer_if.sv
// Handshake bundle between the debug Tx framer, its word source and the UART transmitter.
// master = framer side, slave = source/Tx/requester side.
interface debug_tx_framer_if #(
  parameter int ADDR_W = 6
);
  logic              send;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       word_data;
  logic [7:0]        tx_dato_in;
  logic              tx_start;
  logic              tx_done;

  modport master (
    input  send, word_data, tx_done,
    output busy, done, word_addr, tx_dato_in, tx_start
  );

  modport slave (
    output send, word_data, tx_done,
    input  busy, done, word_addr, tx_dato_in, tx_start
  );
endinterface

// File: rtl/debug_tx_framer.sv
// Debug-link Tx framer: HEADER, length, N_WORDS words LSB-first, XOR checksum,
// paced by the UART tx_start/tx_done handshake.
module debug_tx_framer #(
  parameter int         N_WORDS = 4,
  parameter int         ADDR_W  = 6,
  parameter logic [7:0] HEADER  = 8'hA5
) (
  input  logic         clk,
  input  logic         reset,
  debug_tx_framer_if.master bus
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, LOAD, WAIT, DONE} state_t;
  typedef enum logic [1:0] {PH_HDR, PH_LEN, PH_PAY, PH_CSUM} phase_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);
  localparam logic [7:0]        LEN_BYTE  = 8'(N_WORDS * 4);

  state_t            state_reg, state_next;
  phase_t            phase_reg, phase_next;
  logic [7:0]        byte_q_reg, byte_q_next;
  logic [31:0]       word_sr_reg, word_sr_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [ADDR_W-1:0] word_cnt_reg, word_cnt_next;
  logic [7:0]        csum_reg, csum_next;
  logic [7:0]        dato_reg, dato_next;
  logic              start_reg, start_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              tx_done_prev_reg;
  logic              tx_rise;

  assign tx_rise = bus.tx_done & ~tx_done_prev_reg;

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    byte_q_next   = byte_q_reg;
    word_sr_next  = word_sr_reg;
    byte_cnt_next = byte_cnt_reg;
    word_cnt_next = word_cnt_reg;
    csum_next     = csum_reg;
    dato_next     = dato_reg;
    start_next    = 1'b0;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.send) begin
          state_next    = LOAD;
          phase_next    = PH_HDR;
          byte_q_next   = HEADER;
          byte_cnt_next = 2'd0;
          word_cnt_next = '0;
          csum_next     = 8'h00;
          busy_next     = 1'b1;
        end
      end
      FETCH: state_next = LATCH;
      LATCH: begin
        word_sr_next  = bus.word_data;
        byte_cnt_next = 2'd0;
        state_next    = LOAD;
      end
      LOAD: begin
        // Payload bytes come straight from the bottom of the shift register.
        if (phase_reg == PH_PAY) begin
          dato_next = word_sr_reg[7:0];
          csum_next = csum_reg ^ word_sr_reg[7:0];
        end else begin
          dato_next = byte_q_reg;
        end
        start_next = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (tx_rise) begin
          case (phase_reg)
            PH_HDR: begin
              byte_q_next = LEN_BYTE;
              phase_next  = PH_LEN;
              state_next  = LOAD;
            end
            PH_LEN: begin
              phase_next = PH_PAY;
              state_next = FETCH;
            end
            PH_PAY: begin
              if (byte_cnt_reg != 2'd3) begin
                byte_cnt_next = byte_cnt_reg + 2'd1;
                word_sr_next  = {8'h00, word_sr_reg[31:8]};
                state_next    = LOAD;
              end else if (word_cnt_reg == LAST_WORD) begin
                byte_q_next = csum_reg;
                phase_next  = PH_CSUM;
                state_next  = LOAD;
              end else begin
                word_cnt_next = word_cnt_reg + 1'b1;
                state_next    = FETCH;
              end
            end
            default: begin
              done_next  = 1'b1;
              busy_next  = 1'b0;
              state_next = DONE;
            end
          endcase
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      phase_reg        <= PH_HDR;
      byte_q_reg       <= 8'h00;
      word_sr_reg      <= 32'h0;
      byte_cnt_reg     <= 2'd0;
      word_cnt_reg     <= '0;
      csum_reg         <= 8'h00;
      dato_reg         <= 8'h00;
      start_reg        <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      tx_done_prev_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      phase_reg        <= phase_next;
      byte_q_reg       <= byte_q_next;
      word_sr_reg      <= word_sr_next;
      byte_cnt_reg     <= byte_cnt_next;
      word_cnt_reg     <= word_cnt_next;
      csum_reg         <= csum_next;
      dato_reg         <= dato_next;
      start_reg        <= start_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
      tx_done_prev_reg <= bus.tx_done;
    end
  end

  assign bus.word_addr  = word_cnt_reg;
  assign bus.tx_dato_in = dato_reg;
  assign bus.tx_start   = start_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;

endmodule

// File: tb/tb_debug_tx_framer.sv
// Randomized bench for debug_tx_framer: lane A (N_WORDS=2) and lane B (N_WORDS=1)
// against a byte-level frame model built from the word memories.
module tb_debug_tx_framer;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  debug_tx_framer_if #(.ADDR_W(ADDR_W)) bus_a ();
  debug_tx_framer_if #(.ADDR_W(ADDR_W)) bus_b ();

  debug_tx_framer #(.N_WORDS(2), .ADDR_W(ADDR_W), .HEADER(8'hA5)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.master)
  );
  debug_tx_framer #(.N_WORDS(1), .ADDR_W(ADDR_W), .HEADER(8'hA5)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.master)
  );

  // Word sources: registered read, data valid the cycle after the address changes
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  always @(posedge clk) begin
    bus_a.word_data <= mem_a[bus_a.word_addr];
    bus_b.word_data <= mem_b[bus_b.word_addr];
  end

  // UART Tx models: tx_done rises tx_delay cycles after tx_start, stays high tx_hold cycles
  int   tx_delay = 10;
  int   tx_hold  = 1;
  int   dly_a = 0, hold_a = 0, dly_b = 0, hold_b = 0;
  logic spur_a = 1'b0;
  always @(posedge clk) begin
    if (bus_a.tx_start) dly_a <= tx_delay; else if (dly_a > 0) dly_a <= dly_a - 1;
    if (dly_a == 1 && !bus_a.tx_start) hold_a <= tx_hold; else if (hold_a > 0) hold_a <= hold_a - 1;
    if (bus_b.tx_start) dly_b <= tx_delay; else if (dly_b > 0) dly_b <= dly_b - 1;
    if (dly_b == 1 && !bus_b.tx_start) hold_b <= tx_hold; else if (hold_b > 0) hold_b <= hold_b - 1;
  end
  assign bus_a.tx_done = (hold_a > 0) | spur_a;
  assign bus_b.tx_done = (hold_b > 0);

  // Byte capture
  logic [7:0] cap_a [$];
  logic [7:0] cap_b [$];
  logic [7:0] exp_q [$];
  int max_addr_b = 0;
  always @(negedge clk) begin
    if (bus_a.tx_start) cap_a.push_back(bus_a.tx_dato_in);
    if (bus_b.tx_start) cap_b.push_back(bus_b.tx_dato_in);
    if (int'(bus_b.word_addr) > max_addr_b) max_addr_b = int'(bus_b.word_addr);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame straight from the frame rules
  task automatic build_exp(input int n, input int lane);
    logic [7:0] ck;
    logic [31:0] w;
    ck = 8'h00;
    exp_q = {};
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(n * 4));
    for (int wi = 0; wi < n; wi++) begin
      w = (lane == 0) ? mem_a[wi] : mem_b[wi];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[8*b +: 8]);
        ck = ck ^ w[8*b +: 8];
      end
    end
    exp_q.push_back(ck);
  endtask

  task automatic compare_frame(input string tag, input int lane);
    int n;
    logic [7:0] got_b;
    n = (lane == 0) ? cap_a.size() : cap_b.size();
    check_eq({tag, " nbytes"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      got_b = (lane == 0) ? cap_a[i] : cap_b[i];
      check_eq($sformatf("%s byte%0d", tag, i), 32'(got_b), 32'(exp_q[i]));
    end
    $display("%s: lane %0d, %0d bytes, checksum %02h", tag, lane, n, exp_q[exp_q.size()-1]);
  endtask

  task automatic run_frame_a(input string tag, input bit spam);
    int gaps;
    bit got;
    gaps = 0;
    got = 1'b0;
    cap_a = {};
    bus_a.send = 1'b1;
    @(negedge clk);
    bus_a.send = 1'b0;
    check_eq({tag, " busy T+1"}, 32'(bus_a.busy), 32'd1);
    check_eq({tag, " start T+1"}, 32'(bus_a.tx_start), 32'd0);
    @(negedge clk);
    check_eq({tag, " start T+2"}, 32'(bus_a.tx_start), 32'd1);
    check_eq({tag, " header"}, 32'(bus_a.tx_dato_in), 32'hA5);
    for (int k = 0; k < 5000 && !got; k++) begin
      @(negedge clk);
      if (bus_a.done) got = 1'b1;
      else begin
        if (!bus_a.busy) gaps++;
        if (spam) bus_a.send = 1'($urandom_range(0, 1));
      end
    end
    bus_a.send = 1'b0;
    check_eq({tag, " done seen"}, 32'(got), 32'd1);
    check_eq({tag, " busy gaps"}, 32'(gaps), 32'd0);
    @(negedge clk);
    check_eq({tag, " done pulse"}, 32'(bus_a.done), 32'd0);
    check_eq({tag, " busy off"}, 32'(bus_a.busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    logic [7:0] last_b;
    bus_a.send = 1'b0;
    bus_b.send = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst tx_start", 32'(bus_a.tx_start), 32'd0);
    check_eq("rst tx_dato_in", 32'(bus_a.tx_dato_in), 32'd0);
    check_eq("rst word_addr", 32'(bus_a.word_addr), 32'd0);
    check_eq("rst busy", 32'(bus_a.busy), 32'd0);
    check_eq("rst done", 32'(bus_a.done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed frame
    mem_a[0] = 32'h11223344;
    mem_a[1] = 32'hAABBCCDD;
    run_frame_a("directed", 1'b0);
    build_exp(2, 0);
    compare_frame("directed", 0);
    last_b = cap_a.size() > 10 ? cap_a[10] : 8'hxx;
    check_eq("directed csum", 32'(last_b), 32'h44);

    // Back-to-back: send in the cycle right after done
    run_frame_a("back2back", 1'b0);
    compare_frame("back2back", 0);

    // Randomized frames
    for (int it = 0; it < 6; it++) begin
      mem_a[0] = $urandom;
      mem_a[1] = $urandom;
      tx_delay = $urandom_range(1, 15);
      tx_hold  = $urandom_range(1, tx_delay);
      run_frame_a($sformatf("rand%0d", it), 1'b0);
      build_exp(2, 0);
      compare_frame($sformatf("rand%0d", it), 0);
    end

    // Repeated send while busy
    tx_delay = 10;
    tx_hold  = 1;
    mem_a[0] = $urandom;
    mem_a[1] = $urandom;
    run_frame_a("spam", 1'b1);
    repeat (200) @(negedge clk);
    build_exp(2, 0);
    compare_frame("spam", 0);

    // Spurious tx_done in IDLE, then long tx_done levels
    cap_a = {};
    spur_a = 1'b1;
    @(negedge clk);
    spur_a = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("spur no start", 32'(cap_a.size()), 32'd0);
    check_eq("spur busy", 32'(bus_a.busy), 32'd0);
    tx_delay = 60;
    tx_hold  = 50;
    mem_a[0] = $urandom;
    mem_a[1] = $urandom;
    run_frame_a("held", 1'b0);
    build_exp(2, 0);
    compare_frame("held", 0);
    repeat (60) @(negedge clk);

    // Reset after the 5th byte
    tx_delay = 10;
    tx_hold  = 1;
    cap_a = {};
    mem_a[0] = $urandom;
    mem_a[1] = $urandom;
    bus_a.send = 1'b1;
    @(negedge clk);
    bus_a.send = 1'b0;
    for (int k = 0; k < 1000 && cap_a.size() < 5; k++) @(negedge clk);
    check_eq("rst5 reached", 32'(cap_a.size()), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst5 tx_start", 32'(bus_a.tx_start), 32'd0);
    check_eq("rst5 tx_dato_in", 32'(bus_a.tx_dato_in), 32'd0);
    check_eq("rst5 word_addr", 32'(bus_a.word_addr), 32'd0);
    check_eq("rst5 busy", 32'(bus_a.busy), 32'd0);
    check_eq("rst5 done", 32'(bus_a.done), 32'd0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check_eq("rst5 no more", 32'(cap_a.size()), 32'd5);
    mem_a[0] = $urandom;
    mem_a[1] = $urandom;
    run_frame_a("after_rst", 1'b0);
    build_exp(2, 0);
    compare_frame("after_rst", 0);

    // Lane B: single zero word
    cap_b = {};
    max_addr_b = 0;
    mem_b[0] = 32'h0;
    bus_b.send = 1'b1;
    @(negedge clk);
    bus_b.send = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      if (bus_b.done) got = 1'b1;
    end
    check_eq("n1 done seen", 32'(got), 32'd1);
    build_exp(1, 1);
    compare_frame("n1 zero", 1);
    check_eq("n1 word_addr", 32'(max_addr_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
